// File: rtl/gpu_pkg.sv
// Shared framebuffer geometry, pixel format and write-entry types for the VGA pixel path.
package gpu_pkg;

   localparam int FB_W     = 160;
   localparam int FB_H     = 120;
   localparam int FB_SIZE  = FB_W * FB_H;
   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int DATA_W   = 8;

   typedef struct packed {
      logic [2:0] red;
      logic [2:0] green;
      logic [1:0] blue;
   } pixel_t;

   typedef logic [14:0] fb_addr_t;

   typedef struct packed {
      fb_addr_t addr;
      pixel_t   data;
   } wr_entry_t;

   // row*160 as (row<<7)+(row<<5), so no multiplier is inferred
   function automatic fb_addr_t fb_index(input logic [9:0] x, input logic [9:0] y);
      fb_addr_t row;
      fb_addr_t col;
      row = fb_addr_t'(y >> 2);
      col = fb_addr_t'(x >> 2);
      return (row << 7) + (row << 5) + col;
   endfunction

endpackage

// File: rtl/fb_write_fifo.sv
// Circular write buffer for CPU framebuffer writes; DEPTH must be a power of two >= 2.
module fb_write_fifo
   import gpu_pkg::*;
#(
   parameter int DATA_W = $bits(wr_entry_t),
   parameter int DEPTH  = 4,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wptr;
   logic [PTR_W-1:0]  rptr;
   logic              push_ok;
   logic              pop_ok;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign push_ok  = push && !full;
   assign pop_ok   = pop && !empty;
   assign pop_data = mem[rptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop_ok)  rptr <= rptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr] <= push_data;
   end

endmodule

// File: rtl/vga_pixel_fetch.sv
// Framebuffer fetch stage behind the VGA timing generator, 2-clk latency, with a blanking-drained
// CPU write buffer. Define VGA_PIXEL_BORDER_EN to paint the outermost screen pixels BORDER_COLOR.
module vga_pixel_fetch
   import gpu_pkg::*;
#(
   parameter int         FB_W         = gpu_pkg::FB_W,
   parameter int         FB_H         = gpu_pkg::FB_H,
   parameter int         WBUF_DEPTH   = 4,
   parameter logic [7:0] BORDER_COLOR = 8'hE0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        de_in,
   input  logic [9:0]  x_in,
   input  logic [9:0]  y_in,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [14:0] wr_addr,
   input  logic [7:0]  wr_data,
   output logic        wr_err,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        de_out,
   output logic [2:0]  red,
   output logic [2:0]  green,
   output logic [1:0]  blue
);

   localparam int FB_DEPTH = FB_W * FB_H;
   localparam int CNT_W    = $clog2(WBUF_DEPTH) + 1;

   logic [CNT_W-1:0] wbuf_count;
   logic             wbuf_full;
   logic             wbuf_empty;
   logic             in_range;
   logic             push;
   logic             drain;
   wr_entry_t        push_entry;
   wr_entry_t        pop_entry;
   fb_addr_t         rd_addr;

   pixel_t fb_ram [FB_DEPTH];
   pixel_t ram_q_p0;
   pixel_t pix_p1;
   pixel_t pix_out;
   logic   hs_p0, vs_p0, vld_p0;
   logic   hs_p1, vs_p1, vld_p1;
   logic   border_p1;

   assign in_range   = (wr_addr < 15'(FB_DEPTH));
   assign wr_ready   = (wbuf_count < CNT_W'(WBUF_DEPTH));
   assign push       = wr_valid && !wbuf_full && in_range;
   assign drain      = !de_in && !wbuf_empty;
   assign push_entry = '{addr: wr_addr, data: pixel_t'(wr_data)};
   assign rd_addr    = fb_index(x_in, y_in);

   fb_write_fifo #(
      .DATA_W ($bits(wr_entry_t)),
      .DEPTH  (WBUF_DEPTH),
      .CNT_W  (CNT_W)
   ) u_wbuf (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (drain),
      .pop_data  (pop_entry),
      .count     (wbuf_count),
      .full      (wbuf_full),
      .empty     (wbuf_empty)
   );

   // S0 -> p0: the single RAM port either commits a buffered write (blanking only) or reads the pixel
   always_ff @(posedge clk) begin
      if (drain) fb_ram[pop_entry.addr] <= pop_entry.data;
      else       ram_q_p0               <= fb_ram[rd_addr];
   end

   // p0 -> p1: colour register, aligned with the second sync/de register
   always_ff @(posedge clk) begin
      pix_p1 <= ram_q_p0;
   end

`ifdef VGA_PIXEL_BORDER_EN
   logic border_p0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hs_p0  <= 1'b0;
         vs_p0  <= 1'b0;
         vld_p0 <= 1'b0;
         hs_p1  <= 1'b0;
         vs_p1  <= 1'b0;
         vld_p1 <= 1'b0;
         wr_err <= 1'b0;
`ifdef VGA_PIXEL_BORDER_EN
         border_p0 <= 1'b0;
         border_p1 <= 1'b0;
`endif
      end else begin
         hs_p0  <= hsync_in;
         vs_p0  <= vsync_in;
         vld_p0 <= de_in;
         hs_p1  <= hs_p0;
         vs_p1  <= vs_p0;
         vld_p1 <= vld_p0;
         if (wr_valid && wr_ready && !in_range) wr_err <= 1'b1;
`ifdef VGA_PIXEL_BORDER_EN
         border_p0 <= (x_in == 10'd0) || (x_in == 10'(H_ACTIVE - 1)) ||
                      (y_in == 10'd0) || (y_in == 10'(V_ACTIVE - 1));
         border_p1 <= border_p0;
`endif
      end
   end

`ifndef VGA_PIXEL_BORDER_EN
   assign border_p1 = 1'b0;
`endif

   always_comb begin
      pix_out = '0;
      if (vld_p1) pix_out = border_p1 ? pixel_t'(BORDER_COLOR) : pix_p1;
   end

   assign hsync_out = hs_p1;
   assign vsync_out = vs_p1;
   assign de_out    = vld_p1;
   assign red       = pix_out.red;
   assign green     = pix_out.green;
   assign blue      = pix_out.blue;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: per-cycle scoreboard of colour/sync plus write-buffer status.
module tb_vga_pixel_fetch;
   import gpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hsync_in = 1'b0, vsync_in = 1'b0, de_in = 1'b0;
   logic [9:0]  x_in = '0, y_in = '0;
   logic        wr_valid = 1'b0;
   logic [14:0] wr_addr = '0;
   logic [7:0]  wr_data = '0;
   logic        wr_ready, wr_err, hsync_out, vsync_out, de_out;
   logic [2:0]  red, green;
   logic [1:0]  blue;

   always #5 clk = ~clk;

   vga_pixel_fetch dut (
      .clk(clk), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
      .x_in(x_in), .y_in(y_in), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
      .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out),
      .red(red), .green(green), .blue(blue)
   );

   typedef struct packed { logic hs; logic vs; logic de; logic [7:0] pix; } exp_t;
   typedef struct packed { logic [14:0] a; logic [7:0] d; } wr_t;

   logic [7:0] sh [19200];
   exp_t       sbq [$];
   wr_t        pend [$];
   logic       err_m = 1'b0;
   logic       acc_last = 1'b0;
   int         vectors = 0;
   int         miscompares = 0;

   function automatic logic [7:0] expect_pix(input logic de, input logic [9:0] x, input logic [9:0] y);
      int idx;
      if (!de) return 8'h00;
`ifdef VGA_PIXEL_BORDER_EN
      if (x == 10'd0 || x == 10'd639 || y == 10'd0 || y == 10'd479) return 8'hE0;
`endif
      idx = (int'(y) / 4) * 160 + int'(x) / 4;
      return sh[idx];
   endfunction

   task automatic step(input logic hs, input logic vs, input logic de,
                       input logic [9:0] x, input logic [9:0] y);
      exp_t e;
      exp_t o;
      logic acc, popm, rdy_e;
      wr_t  w;
      hsync_in = hs; vsync_in = vs; de_in = de; x_in = x; y_in = y;
      e = '{hs: hs, vs: vs, de: de, pix: expect_pix(de, x, y)};
      sbq.push_back(e);
      acc  = wr_valid && (pend.size() < 4);
      popm = !de && (pend.size() > 0);
      @(negedge clk);
      if (popm) begin
         w = pend.pop_front();
         sh[w.a] = w.d;
      end
      if (acc) begin
         if (wr_addr < 15'd19200) pend.push_back('{a: wr_addr, d: wr_data});
         else err_m = 1'b1;
      end
      acc_last = acc;
      if (sbq.size() >= 2) begin
         e = sbq.pop_front();
         o = '{hs: hsync_out, vs: vsync_out, de: de_out, pix: {red, green, blue}};
         vectors++;
         assert (o === e) else begin
            miscompares++;
            $error("FAIL pipe obs=%h exp=%h", o, e);
         end
      end
      rdy_e = (pend.size() < 4);
      vectors++;
      assert ({wr_ready, wr_err} === {rdy_e, err_m}) else begin
         miscompares++;
         $error("FAIL status ready/err obs=%b%b exp=%b%b", wr_ready, wr_err, rdy_e, err_m);
      end
   endtask

   task automatic blank(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 10'd0, 10'd0);
   endtask

   task automatic wr_blank(input logic [14:0] a, input logic [7:0] d);
      wr_valid = 1'b1; wr_addr = a; wr_data = d;
      blank(1);
      wr_valid = 1'b0;
   endtask

   task automatic scan(input logic [9:0] y);
      for (int x = 0; x < 16; x++) step(1'b0, 1'b0, 1'b1, 10'(x), y);
      for (int x = 632; x < 640; x++) step(1'b0, 1'b0, 1'b1, 10'(x), y);
      for (int i = 0; i < 8; i++) step((i >= 2 && i < 6), 1'b0, 1'b0, 10'd0, 10'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      logic [10:0] o;
      o = {hsync_out, vsync_out, de_out, red, green, blue};
      vectors++;
      assert ({o, wr_err, wr_ready} === {11'd0, 1'b0, 1'b1}) else begin
         miscompares++;
         $error("FAIL %s obs=%h/%b/%b exp=000/0/1", tag, o, wr_err, wr_ready);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      hsync_in = 1'b1; vsync_in = 1'b1; de_in = 1'b1;
      #2 check_reset_outputs("reset_async");
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("reset_hold");
      rst = 1'b0;
      sbq.delete();
      pend.delete();
      err_m = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 19200; i++) sh[i] = 8'h00;
      #1 check_reset_outputs("reset_initial");
      @(negedge clk);
      @(negedge clk);
      check_reset_outputs("reset_initial_hold");
      rst = 1'b0;

      // Clear every framebuffer cell the scans below look at
      for (int r = 0; r < 5; r++) begin
         for (int c = 0; c < 6; c++) begin
            int row, col;
            row = (r == 4) ? 119 : r;
            col = (c < 4) ? c : 154 + c;
            wr_blank(15'(row * 160 + col), 8'h00);
         end
      end
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 10'd0, 10'd0);
      blank(4);
      for (int y = 0; y < 16; y++) scan(10'(y));
      for (int y = 476; y < 480; y++) scan(10'(y));

      // Two blanking writes: white block at (0..3,0..3), green block at (4..7,4..7)
      wr_blank(15'd0, 8'hFF);
      wr_blank(15'd161, 8'h1C);
      blank(4);
      for (int y = 0; y < 8; y++) scan(10'(y));

      // Fill the buffer during active display, then hold a fifth write until blanking
      begin
         logic [14:0] aa [5];
         logic [7:0]  dd [5];
         int          guard;
         aa[0] = 15'd1;   dd[0] = 8'hAA;
         aa[1] = 15'd2;   dd[1] = 8'h55;
         aa[2] = 15'd3;   dd[2] = 8'h0F;
         aa[3] = 15'd160; dd[3] = 8'hF0;
         aa[4] = 15'd162; dd[4] = 8'h33;
         for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_addr = aa[i]; wr_data = dd[i];
            step(1'b0, 1'b0, 1'b1, 10'(i), 10'd12);
         end
         wr_addr = aa[4]; wr_data = dd[4];
         for (int i = 4; i < 10; i++) step(1'b0, 1'b0, 1'b1, 10'(i), 10'd12);
         guard = 0;
         acc_last = 1'b0;
         while (!acc_last && guard < 10) begin
            blank(1);
            guard++;
         end
         wr_valid = 1'b0;
         vectors++;
         assert (acc_last === 1'b1) else begin
            miscompares++;
            $error("FAIL held_write_accept obs=%b exp=1", acc_last);
         end
      end
      blank(6);
      for (int y = 0; y < 8; y++) scan(10'(y));

      // Out-of-range write sets the sticky error and leaves RAM alone
      wr_blank(15'd19200, 8'h77);
      blank(4);
      scan(10'd0);
      scan(10'd476);
      wr_blank(15'd2, 8'h81);
      blank(4);
      scan(10'd1);

      // Reset with three buffered entries discards them
      for (int i = 0; i < 3; i++) begin
         wr_valid = 1'b1; wr_addr = 15'(i); wr_data = 8'h99;
         step(1'b0, 1'b0, 1'b1, 10'(i), 10'd12);
      end
      wr_valid = 1'b0;
      do_reset();
      blank(8);
      for (int y = 0; y < 4; y++) scan(10'(y));
      scan(10'd479);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
